// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by instr_fetch: FETCH_PERF_CNT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  // Field bounds inside the 32-bit instruction word
  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  localparam int INSTR_BYTES = 4;
  localparam int PERF_W      = 32;

endpackage

// File: rtl/instr_fields.sv
// Combinational split of the instruction register into the decode fields.
module instr_fields
  import fetch_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [3:0]  o_cond,
  output logic [1:0]  o_op,
  output logic [5:0]  o_funct,
  output logic [3:0]  o_rd
);

  // Bits not consumed by decode here (Rn and operand2) are folded away
  logic w_unused_bits;

  assign o_cond        = i_instr[COND_HI:COND_LO];
  assign o_op          = i_instr[OP_HI:OP_LO];
  assign o_funct       = i_instr[FUNCT_HI:FUNCT_LO];
  assign o_rd          = i_instr[RD_HI:RD_LO];
  assign w_unused_bits = ^{i_instr[19:16], i_instr[11:0]};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack fetch FSM, instruction register,
// branch redirect. Optional macro FETCH_PERF_CNT_EN adds saturating
// fetch/stall performance counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] R15_OFFSET  = ADDR_W'(2 * INSTR_BYTES);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic              r_imem_req;
  logic              w_ack_taken;

  // An ack only counts while a request is actually outstanding
  assign w_ack_taken = imem_ack & r_imem_req;

  // Fetch FSM with PC, instruction register and registered request
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC_AL;
      r_pc_out      <= RESET_PC_AL;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (w_ack_taken) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_pc;
            r_pc          <= r_pc + PC_STEP;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
            if (branch_en) begin
              r_pc <= branch_target & ALIGN_MASK;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_fetch_cnt;
  logic [PERF_W-1:0] r_perf_stall_cnt;
  logic              w_stall_cycle;

  assign w_stall_cycle = ((r_state == VALID) && stall) ||
                         ((r_state == FETCH) && !imem_ack);

  // Saturating counters: captured fetches and cycles lost to stall/wait
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if ((r_state == FETCH) && w_ack_taken && (r_perf_fetch_cnt != '1)) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 1'b1;
      end
      if (w_stall_cycle && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc_out;
  assign pc_plus8    = r_pc_out + R15_OFFSET;

  instr_fields u_fields (
    .i_instr (r_instr[31:0]),
    .o_cond  (cond),
    .o_op    (op),
    .o_funct (funct),
    .o_rd    (rd)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed stimulus, a transaction-level
// model checked every cycle, and literal expectations pinning the model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_en;
  logic [31:0] branch_target;
  logic        force_ack;
  int          waits;
  int          wcnt;
  bit          check_on = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  // main DUT signals
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus8;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;

  // second DUT (reset PC at top of address space)
  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, instr2, pc_out2, pc_plus8_2;
  logic [3:0]  cond2, rd2;
  logic [1:0]  op2;
  logic [5:0]  funct2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt2, perf_stall_cnt2;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE281_1001 + a;
  endfunction

  // Memory: ack after 'waits' cycles of request, or forced (late/stray ack)
  assign imem_ack   = force_ack | (imem_req && (wcnt == waits));
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus8(pc_plus8),
    .cond(cond), .op(op), .funct(funct), .rd(rd)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_req2), .imem_rdata(mem_word(imem_addr2)),
    .stall(1'b0), .branch_en(1'b0), .branch_target(32'h0),
    .instr(instr2), .instr_valid(instr_valid2),
    .pc_out(pc_out2), .pc_plus8(pc_plus8_2),
    .cond(cond2), .op(op2), .funct(funct2), .rd(rd2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt2), .perf_stall_cnt(perf_stall_cnt2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 = just out of reset, 1 = waiting for a
  // word, 2 = holding a word for downstream.
  int          m_phase;
  logic [31:0] m_pc, m_pc_out, m_instr;
  logic        m_valid;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase <= 0; m_pc <= 32'h0; m_pc_out <= 32'h0; m_instr <= 32'h0; m_valid <= 1'b0;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: if (imem_ack) begin
             m_instr  <= mem_word(m_pc);
             m_pc_out <= m_pc;
             m_pc     <= m_pc + 32'd4;
             m_valid  <= 1'b1;
             m_phase  <= 2;
           end
        default: if (!stall) begin
             m_valid <= 1'b0;
             m_phase <= 1;
             if (branch_en) m_pc <= (branch_target / 4) * 4;
           end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_on) begin
      chk("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("m_req", {31'b0, imem_req}, {31'b0, (m_phase == 1)});
      if (m_phase == 1) chk("m_addr", imem_addr, m_pc);
      chk("m_instr", instr, m_instr);
      chk("m_pc_out", pc_out, m_pc_out);
      chk("m_pc_plus8", pc_plus8, m_pc_out + 32'd8);
      chk("m_cond", {28'b0, cond}, m_instr >> 28);
      chk("m_op", {30'b0, op}, (m_instr >> 26) & 32'h3);
      chk("m_funct", {26'b0, funct}, (m_instr >> 20) & 32'h3F);
      chk("m_rd", {28'b0, rd}, (m_instr >> 12) & 32'hF);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 32'h0;
    waits = 0; force_ack = 1'b0; wcnt = 0;
    step(); step();
    check_on = 1'b1;
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst2_pc_out", pc_out2, 32'hFFFF_FFFC);
    $display("reset applied");

    // zero-wait fetches at 0,4 and 8
    rst = 1'b1;
    step();
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t5_addr_top", imem_addr2, 32'hFFFF_FFFC);
    step();
    chk("t1_valid", {31'b0, instr_valid}, 32'h1);
    chk("t1_instr", instr, 32'hE281_1001);
    chk("t1_cond", {28'b0, cond}, 32'hE);
    chk("t1_op", {30'b0, op}, 32'h0);
    chk("t1_funct", {26'b0, funct}, 32'h28);
    chk("t1_rd", {28'b0, rd}, 32'h1);
    chk("t5_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("t5_pc_plus8", pc_plus8_2, 32'h4);
    $display("fetch addr=%h instr=%h", pc_out, instr);
    step();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t5_wrap", imem_addr2, 32'h0);
    step();
    chk("t1_pc_out4", pc_out, 32'h4);
    chk("t1_instr4", instr, 32'hE281_1005);
    $display("fetch addr=%h instr=%h", pc_out, instr);

    // three wait cycles on the fetch of 8
    waits = 3;
    step();
    chk("t2_addr8", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_addr_hold", imem_addr, 32'h8);
      chk("t2_not_valid", {31'b0, instr_valid}, 32'h0);
    end
    step();
    chk("t2_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_pc_out", pc_out, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_perf_fetch", perf_fetch_cnt, 32'd3);
    chk("t2_perf_stall", perf_stall_cnt, 32'd3);
`endif
    $display("fetch addr=%h instr=%h (3 waits)", pc_out, instr);

    // stall for 5 cycles, with an ignored branch pulse in the middle
    waits = 0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_en = (i == 2); branch_target = 32'h200;
      step();
      chk("t3_hold_valid", {31'b0, instr_valid}, 32'h1);
      chk("t3_hold_pc", pc_out, 32'h8);
      chk("t3_no_req", {31'b0, imem_req}, 32'h0);
    end
    branch_en = 1'b0; stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_stall", perf_stall_cnt, 32'd8);
`endif
    step();
    chk("t3_next_addr", imem_addr, 32'hC);
    step();
    $display("fetch addr=%h instr=%h (after stall)", pc_out, instr);

    // taken branch to unaligned target, then branch pulse during FETCH
    branch_en = 1'b1; branch_target = 32'h103;
    step();
    chk("t4_branch_addr", imem_addr, 32'h100);
    branch_target = 32'h300;
    step();
    chk("t4_pc_out", pc_out, 32'h100);
    $display("fetch addr=%h instr=%h (branch)", pc_out, instr);
    branch_en = 1'b0; waits = 5;
    step();
    chk("t4_seq_addr", imem_addr, 32'h104);
    step();
    chk("t6_mid_fetch", {31'b0, instr_valid}, 32'h0);

    // reset mid-FETCH, then a late ack
    rst = 1'b0;
    step();
    chk("t6_req", {31'b0, imem_req}, 32'h0);
    chk("t6_pc_out", pc_out, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_cond", {28'b0, cond}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
    force_ack = 1'b1;
    step();
    chk("t6_ack_in_rst", {31'b0, instr_valid}, 32'h0);
    rst = 1'b1;
    step();
    chk("t6_ack_idle", {31'b0, instr_valid}, 32'h0);
    chk("t6_restart_req", {31'b0, imem_req}, 32'h1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    force_ack = 1'b0; waits = 0;
    step();
    chk("t6_refetch", instr, 32'hE281_1001);
    $display("fetch addr=%h instr=%h (after reset)", pc_out, instr);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
